// File: rtl/selevy_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// the default frame marker and the memory word width.
package selevy_pkg;

  localparam int WORD_W = 32;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CNT0,
    CNT1,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port of the loader.
interface imem_loader_if;
  import selevy_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects four bytes, least-significant first, into a 32-bit word.
module word_assembler
  import selevy_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic [7:0]        data_byte,
  input  logic              load,
  input  logic              clear,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [1:0] idx_reg;
  logic [7:0] lane_reg [4];

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      idx_reg <= 2'd0;
    end else if (load) begin
      idx_reg <= idx_reg + 2'd1;
    end
  end

  // Each lane takes its upper neighbour; the top lane takes the new byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (srst || clear) begin
          lane_reg[gi] <= 8'd0;
        end else if (load) begin
          if (gi == 3) begin
            lane_reg[gi] <= data_byte;
          end else begin
            lane_reg[gi] <= lane_reg[(gi + 1) % 4];
          end
        end
      end
    end
  endgenerate

  // The word is presented in the same cycle as its 4th byte arrives.
  assign full = load && (idx_reg == 2'd3);
  assign word = {data_byte, lane_reg[3], lane_reg[2], lane_reg[1]};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream, writes words to instruction memory,
// verifies the XOR checksum and holds the core in reset until a good image lands.
module imem_loader
  import selevy_pkg::*;
#(
  parameter int         DEPTH_WORDS = 256,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
  input  logic         CLK,
  input  logic         reset,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  loader_state_e     state_reg, state_next;
  logic [7:0]        cnt_lo_reg;
  logic [15:0]       cnt_reg;
  logic [15:0]       word_idx_reg;
  logic [7:0]        csum_reg;
  logic              mem_we_reg;
  logic [WORD_W-1:0] mem_addr_reg;
  logic [WORD_W-1:0] mem_wdata_reg;
  logic              cpu_hold_reg;
  logic              done_reg;
  logic              err_reg;

  logic              fire;
  logic              sync_hit;
  logic              csum_upd;
  logic              asm_load;
  logic              asm_full;
  logic [WORD_W-1:0] asm_word;
  logic [15:0]       cnt_full;
  logic [15:0]       word_idx_inc;

  assign bus.in_ready = (state_reg != WRITE);
  assign fire         = bus.in_valid && bus.in_ready;
  assign cnt_full     = {bus.in_data, cnt_lo_reg};
  assign word_idx_inc = word_idx_reg + 16'd1;

  word_assembler u_asm (
    .clk       (CLK),
    .srst      (reset),
    .data_byte (bus.in_data),
    .load      (asm_load),
    .clear     (sync_hit),
    .word      (asm_word),
    .full      (asm_full)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sync_hit   = 1'b0;
    csum_upd   = 1'b0;
    asm_load   = 1'b0;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (fire && bus.in_data == SYNC_BYTE) begin
          sync_hit   = 1'b1;
          state_next = CNT0;
        end
      end
      CNT0: begin
        if (fire) begin
          csum_upd   = 1'b1;
          state_next = CNT1;
        end
      end
      CNT1: begin
        if (fire) begin
          csum_upd = 1'b1;
          if ({1'b0, cnt_full} > DEPTH_L) begin
            state_next = ERR;
          end else if (cnt_full == 16'd0) begin
            state_next = CSUM;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (fire) begin
          csum_upd = 1'b1;
          asm_load = 1'b1;
          if (asm_full) begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        state_next = (word_idx_inc == cnt_reg) ? CSUM : DATA;
      end
      CSUM: begin
        if (fire) begin
          state_next = (bus.in_data == csum_reg) ? DONE : ERR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_lo_reg    <= 8'd0;
      cnt_reg       <= 16'd0;
      word_idx_reg  <= 16'd0;
      csum_reg      <= 8'd0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cpu_hold_reg  <= 1'b1;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      if (state_reg == CNT0 && fire) begin
        cnt_lo_reg <= bus.in_data;
      end
      if (state_reg == CNT1 && fire) begin
        cnt_reg <= cnt_full;
      end
      if (sync_hit) begin
        csum_reg     <= 8'd0;
        word_idx_reg <= 16'd0;
      end else begin
        if (csum_upd) begin
          csum_reg <= csum_reg ^ bus.in_data;
        end
        if (state_reg == WRITE) begin
          word_idx_reg <= word_idx_inc;
        end
      end
      // WRITE is only entered from DATA, so this is a single-cycle strobe.
      mem_we_reg <= (state_next == WRITE);
      if (state_next == WRITE) begin
        mem_addr_reg  <= WORD_W'({word_idx_reg, 2'b00});
        mem_wdata_reg <= asm_word;
      end
      cpu_hold_reg <= (state_next != DONE);
      done_reg     <= (state_next == DONE);
      err_reg      <= (state_next == ERR);
    end
  end

  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign cpu_hold      = cpu_hold_reg;
  assign done          = done_reg;
  assign err           = err_reg;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory that the core fetches from. It consumes a framed byte stream from a serial receiver and assembles little-endian 32-bit words. It writes those words sequentially into the instruction memory write port and verifies an XOR checksum. While loading, it holds the core in reset; it releases the core only after a complete, verified image.

## Interface

**Parameters**
- `DEPTH_WORDS`, default 256: instruction memory capacity in words; larger counts are rejected.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

**Ports**
- `CLK`, input, 1: single clock; all logic is rising-edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_data`, input, 8: received byte.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_ready`, output, 1: loader accepts a byte this cycle. A transfer occurs when `in_valid` and `in_ready` are both high.
- `mem_we`, output, 1: one-cycle write strobe to the instruction memory.
- `mem_addr`, output, 32: byte address of the write (word-aligned).
- `mem_wdata`, output, 32: write data.
- `cpu_hold`, output, 1: high keeps the core in reset.
- `done`, output, 1: image loaded and checksum passed (sticky).
- `err`, output, 1: frame rejected (sticky).

## Operation

**Frame format:** `SYNC_BYTE`, `CNT_LO`, `CNT_HI`, then `N` = {`CNT_HI`,`CNT_LO`} words of 4 bytes each (least-significant byte first), then `CSUM`.
- `CSUM` is the XOR of every byte from `CNT_LO` through the last data byte.

**State machine:**
- **IDLE:** bytes other than `SYNC_BYTE` are discarded. `SYNC_BYTE` clears the checksum, word index and byte index, then goes to CNT0.
- **CNT0:** latch the low count byte → CNT1.
- **CNT1:** latch the high count byte.
  - If `N > DEPTH_WORDS` → ERR.
  - If `N == 0` → CSUM.
  - Otherwise → DATA.
- **DATA:** shift each byte into the word assembler. On the 4th byte → WRITE.
- **WRITE:** exactly one cycle.
  - `mem_we=1`, `mem_addr = word_index*4`, `mem_wdata` = assembled word.
  - Increment `word_index`.
  - If `word_index+1 == N` → CSUM; otherwise → DATA.
- **CSUM:** if the received byte equals the running XOR → DONE; otherwise → ERR.
- **DONE / ERR:** non-sync bytes are discarded. `SYNC_BYTE` restarts loading as in IDLE and clears `done`/`err`.

**Outputs:**
- `cpu_hold` is high in every state except DONE.
- `done` is high only in DONE; `err` is high only in ERR.
- Each accepted byte updates the running XOR, except the sync byte and the `CSUM` byte.

**Reset:**
- Reset at any point, including mid-frame or during WRITE, returns to IDLE.
- A partially written image is abandoned and `cpu_hold` stays high.
- Reset takes priority over a simultaneous byte transfer, which is lost.

## Timing

**Reset values:** state IDLE, `in_ready=1`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `cpu_hold=1`, `done=0`, `err=0`.

**Register and handshake rules:**
- All outputs are registered, except `in_ready`, which is decoded from state: low only in WRITE.
- `in_valid` held high during WRITE is not consumed; the byte must be presented again and is taken on the next cycle.

**Latency:**
- From acceptance of a word's 4th byte to the `mem_we` pulse: 1 cycle.
- From `CSUM` acceptance to `done`/`err` and `cpu_hold` fall: 1 cycle.

**Throughput:** at most one byte per cycle, i.e. 4 bytes per 5 cycles during DATA/WRITE.

**Write port hold:** `mem_addr` and `mem_wdata` hold their last values while `mem_we=0`.

## Structure

**Shared package `selevy_pkg`:**
- Loader state enum (IDLE, CNT0, CNT1, DATA, WRITE, CSUM, DONE, ERR).
- Default `SYNC_BYTE`.
- Word width constant (32).

**Sub-module `word_assembler`:**
- 2-bit byte index plus a 32-bit shift register.
- Inputs: byte, load strobe, clear.
- Outputs: assembled word and a `full` flag on the 4th byte.
- Instantiated once; the FSM, count, address and checksum logic stay in `imem_loader`.

## Test plan

1. **Two-word load:** stream `A5 02 00 13 00 00 00 93 00 10 00 CS`, with `CS` = XOR of bytes `CNT_LO` through the last data byte.
   - Expected: `mem_we` pulses writing 0x00000013 at addr 0, then 0x00100093 at addr 4.
   - Then `done=1` and `cpu_hold=0` one cycle after `CS`.
2. **Bad checksum:** same frame with `CS^8'h01` → `err=1`, `done=0`, `cpu_hold` stays 1. A following correct frame → `done=1`, `err=0`.
3. **Oversize count:** `A5 01 01` with `DEPTH_WORDS=256` (N=257) → `err=1` after CNT1 with no `mem_we` pulse. Garbage bytes then keep `err=1` until `A5`.
4. **Zero count:** `A5 00 00 00` → `done=1` with no writes.
5. **Backpressure and noise:** hold `in_valid=1` continuously, with leading `FF 00` before `A5`.
   - Noise bytes are ignored.
   - `in_ready=0` for exactly one cycle per word, and no data byte is lost or duplicated.
6. **Mid-frame reset:** assert `reset` for 1 cycle after the 6th data byte → state IDLE, `cpu_hold=1`, `mem_we=0`. A fresh frame then loads from addr 0.
